display_bcd_scanner: RTL

//  Downstream display stage of the calculator: takes the 14-bit number chosen by the display mux,

---
 rtl/display_bcd_scanner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/display_bcd_scanner.sv
// Converts a 14-bit value to four BCD digits with a serial double-dabble engine and
// scans them onto a 4-digit common-anode 7-segment display. Leading zeros are blanked and values above 9999 show dashes.
module display_bcd_scanner #(
    parameter int REFRESH_OVERFLOW = 2**19 - 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] to_display_nr,
    output logic [3:0]  digit_select,
    output logic [6:0]  led_select,
    output logic        busy
);

    localparam int CNT_W = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     iter_q, iter_d;
    logic [13:0]    shift_q, shift_d;
    logic [15:0]    scratch_q, scratch_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    shown_q, shown_d;
    logic           shown_ovf_q, shown_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    adjusted;
    logic [3:0]     cur_digit;
    logic           cur_blank;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int n = 0; n < 4; n++) begin
            if (s[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = s[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign adjusted = dabble_adjust(scratch_q);

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        ovf_d       = ovf_q;
        shown_d     = shown_q;
        shown_ovf_d = shown_ovf_q;
        case (state_q)
            IDLE: begin
                shift_d   = to_display_nr;
                scratch_d = 16'd0;
                ovf_d     = (to_display_nr > 14'd9999);
                iter_d    = 4'd0;
                state_d   = CONV;
            end
            CONV: begin
                {scratch_d, shift_d} = {adjusted[14:0], shift_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) state_d = LOAD;
            end
            LOAD: begin
                // Shown regs only change here, so the display never sees a partial result.
                shown_d     = scratch_q;
                shown_ovf_d = ovf_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_OVERFLOW)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            iter_q      <= 4'd0;
            ovf_q       <= 1'b0;
            shown_q     <= 16'd0;
            shown_ovf_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            ovf_q       <= ovf_d;
            shown_q     <= shown_d;
            shown_ovf_q <= shown_ovf_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
        end
    end

    // Scratch and shift regs are reloaded in IDLE before use, so they need no reset.
    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        scratch_q <= scratch_d;
    end

    assign cur_digit = shown_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        case (idx_q)
            2'd3:    cur_blank = (shown_q[15:12] == 4'd0);
            2'd2:    cur_blank = (shown_q[15:8] == 8'd0);
            2'd1:    cur_blank = (shown_q[15:4] == 12'd0);
            default: cur_blank = 1'b0;
        endcase
    end

    always_comb begin
        digit_select = ~(4'b0001 << idx_q);
        if (shown_ovf_q)    led_select = SEG_DASH;
        else if (cur_blank) led_select = SEG_BLANK;
        else                led_select = seg_decode(cur_digit);
        busy = (state_q == CONV) || (state_q == LOAD);
    end

endmodule
